// File: rtl/mandel_engine.sv
// Fixed-point escape-time engine: scans a px/py grid in Mandelbrot or Julia mode,
// iterating z = z^2 + c with one shared sign-magnitude multiplier, and streams one result per pixel.
module mandel_engine #(
    parameter int N_BIT    = 16,
    parameter int BIT_FRAC = 12,
    parameter int PX_W     = 8,
    parameter int PY_W     = 8,
    parameter int IT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_start,
    input  logic                    cfg_abort,
    input  logic                    cfg_mode,
    input  logic signed [N_BIT-1:0] cfg_cxs,
    input  logic signed [N_BIT-1:0] cfg_cys,
    input  logic signed [N_BIT-1:0] cfg_dcx,
    input  logic signed [N_BIT-1:0] cfg_dcy,
    input  logic signed [N_BIT-1:0] cfg_jx,
    input  logic signed [N_BIT-1:0] cfg_jy,
    input  logic [PX_W-1:0]         cfg_npx,
    input  logic [PY_W-1:0]         cfg_npy,
    input  logic [IT_W-1:0]         cfg_max_iter,
    output logic                    busy,
    output logic                    done,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PX_W-1:0]         out_px,
    output logic [PY_W-1:0]         out_py,
    output logic [IT_W-1:0]         out_iter,
    output logic                    out_inset
);

    localparam logic [N_BIT:0] ESC_TH = (N_BIT+1)'(4 << BIT_FRAC);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_M_XX, S_M_YY, S_M_XY, S_CHK, S_EMIT, S_DONE
    } state_t;

    state_t state, state_nxt;

    // Magnitudes are multiplied and truncated, so rounding is toward zero for both signs.
    function automatic logic signed [N_BIT-1:0] fx_mul(input logic signed [N_BIT-1:0] a,
                                                       input logic signed [N_BIT-1:0] b);
        logic [N_BIT-1:0] ma, mb, r;
        ma = a[N_BIT-1] ? $unsigned(-a) : $unsigned(a);
        mb = b[N_BIT-1] ? $unsigned(-b) : $unsigned(b);
        r  = N_BIT'(({{N_BIT{1'b0}}, ma} * {{N_BIT{1'b0}}, mb}) >> BIT_FRAC);
        return (a[N_BIT-1] ^ b[N_BIT-1]) ? $signed(-r) : $signed(r);
    endfunction

    // abs of the most negative value stays 0x8..0, which reads as a large unsigned magnitude.
    function automatic logic [N_BIT-1:0] abs_u(input logic signed [N_BIT-1:0] v);
        return v[N_BIT-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    logic                    mode_r;
    logic signed [N_BIT-1:0] cys_r, dcx_r, dcy_r, jx_r, jy_r;
    logic [PX_W-1:0]         npx_r, px_r;
    logic [PY_W-1:0]         npy_r, py_r;
    logic [IT_W-1:0]         max_r, n_r;
    logic signed [N_BIT-1:0] p_r, q_r, x_r, y_r, xx_r, yy_r, xy_r;
    logic                    inset_r;

    logic signed [N_BIT-1:0] cr, ci, mul_a, mul_b, mul_p, x_new, y_new;
    logic [N_BIT:0]          mag_sum;
    logic                    esc, hit_max, last_px, last_py, xfer;
    logic [IT_W-1:0]         n_inc;

    always_comb begin
        cr = mode_r ? jx_r : p_r;
        ci = mode_r ? jy_r : q_r;
        mul_a = x_r;
        mul_b = x_r;
        case (state)
            S_M_YY: begin mul_a = y_r;       mul_b = y_r; end
            S_M_XY: begin mul_a = x_r <<< 1; mul_b = y_r; end
            default: ;
        endcase
        mul_p   = fx_mul(mul_a, mul_b);
        x_new   = xx_r - yy_r + cr;
        y_new   = xy_r + ci;
        mag_sum = {1'b0, abs_u(x_new)} + {1'b0, abs_u(y_new)};
        esc     = (mag_sum >= ESC_TH);
        n_inc   = n_r + IT_W'(1);
        hit_max = (n_inc == max_r);
        last_px = (px_r == npx_r - PX_W'(1));
        last_py = (py_r == npy_r - PY_W'(1));
        xfer    = (state == S_EMIT) && out_ready;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (cfg_start)
                        state_nxt = (cfg_npx == '0 || cfg_npy == '0) ? S_DONE : S_INIT;
            S_INIT: state_nxt = (max_r == '0) ? S_EMIT : S_M_XX;
            S_M_XX: state_nxt = S_M_YY;
            S_M_YY: state_nxt = S_M_XY;
            S_M_XY: state_nxt = S_CHK;
            S_CHK:  state_nxt = (esc || hit_max) ? S_EMIT : S_M_XX;
            S_EMIT: if (xfer) state_nxt = (last_px && last_py) ? S_DONE : S_INIT;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (cfg_abort && state != S_IDLE)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            mode_r <= 1'b0;
            cys_r <= '0; dcx_r <= '0; dcy_r <= '0; jx_r <= '0; jy_r <= '0;
            npx_r <= '0; npy_r <= '0; max_r <= '0;
            p_r <= '0; q_r <= '0; x_r <= '0; y_r <= '0;
            xx_r <= '0; yy_r <= '0; xy_r <= '0;
            px_r <= '0; py_r <= '0; n_r <= '0; inset_r <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (cfg_start) begin
                    mode_r <= cfg_mode;
                    cys_r <= cfg_cys; dcx_r <= cfg_dcx; dcy_r <= cfg_dcy;
                    jx_r <= cfg_jx; jy_r <= cfg_jy;
                    npx_r <= cfg_npx; npy_r <= cfg_npy; max_r <= cfg_max_iter;
                    p_r <= cfg_cxs; q_r <= cfg_cys;
                    px_r <= '0; py_r <= '0;
                end
                S_INIT: begin
                    x_r <= mode_r ? p_r : '0;
                    y_r <= mode_r ? q_r : '0;
                    n_r <= '0;
                    inset_r <= (max_r == '0);
                end
                S_M_XX: xx_r <= mul_p;
                S_M_YY: yy_r <= mul_p;
                S_M_XY: xy_r <= mul_p;
                S_CHK: begin
                    x_r <= x_new;
                    y_r <= y_new;
                    if (!esc) n_r <= n_inc;
                    inset_r <= !esc && hit_max;
                end
                S_EMIT: if (xfer) begin
                    // py is the inner loop; q restarts from cys when px advances
                    if (!last_py) begin
                        py_r <= py_r + PY_W'(1);
                        q_r  <= q_r + dcy_r;
                    end else if (!last_px) begin
                        py_r <= '0;
                        q_r  <= cys_r;
                        px_r <= px_r + PX_W'(1);
                        p_r  <= p_r + dcx_r;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign out_valid = (state == S_EMIT);
    assign out_px    = px_r;
    assign out_py    = py_r;
    assign out_iter  = n_r;
    assign out_inset = inset_r;

endmodule

// File: tb/tb_mandel_engine.sv
// Directed bench for mandel_engine: hand-computed orbits, grid order, backpressure, abort and reset.
module tb_mandel_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0, cfg_abort = 1'b0, cfg_mode = 1'b0;
    logic signed [15:0] cfg_cxs = '0, cfg_cys = '0, cfg_dcx = '0, cfg_dcy = '0;
    logic signed [15:0] cfg_jx = '0, cfg_jy = '0;
    logic [7:0]  cfg_npx = '0, cfg_npy = '0, cfg_max_iter = '0;
    logic        busy, done, out_valid, out_inset;
    logic        out_ready = 1'b1;
    logic [7:0]  out_px, out_py, out_iter;

    int n_checks = 0;
    int n_errors = 0;

    mandel_engine dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_mode(cfg_mode),
        .cfg_cxs(cfg_cxs), .cfg_cys(cfg_cys), .cfg_dcx(cfg_dcx), .cfg_dcy(cfg_dcy),
        .cfg_jx(cfg_jx), .cfg_jy(cfg_jy), .cfg_npx(cfg_npx), .cfg_npy(cfg_npy),
        .cfg_max_iter(cfg_max_iter), .busy(busy), .done(done), .out_valid(out_valid),
        .out_ready(out_ready), .out_px(out_px), .out_py(out_py), .out_iter(out_iter),
        .out_inset(out_inset)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start pulse in cycle 0; returns at the negedge of cycle 1 with cfg scrambled.
    task automatic start_scan(input logic mode, input logic [15:0] cxs, input logic [15:0] cys,
                              input logic [15:0] dcx, input logic [15:0] dcy,
                              input logic [7:0] npx, input logic [7:0] npy, input logic [7:0] mx);
        @(negedge clk);
        cfg_mode = mode; cfg_cxs = cxs; cfg_cys = cys; cfg_dcx = dcx; cfg_dcy = dcy;
        cfg_jx = '0; cfg_jy = '0; cfg_npx = npx; cfg_npy = npy; cfg_max_iter = mx;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_mode = ~mode; cfg_cxs = 16'h5555; cfg_cys = 16'h3333; cfg_dcx = 16'h1111;
        cfg_dcy = 16'h7777; cfg_jx = 16'h2222; cfg_jy = 16'h4444;
        cfg_npx = 8'h00; cfg_npy = 8'h00; cfg_max_iter = 8'h01;
    endtask

    task automatic wait_valid(input int cyc0, output int cyc);
        cyc = cyc0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!out_valid && cyc < 3000);
        chk("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    int cyc, ndone;
    logic [7:0] exp_px [6] = '{0, 0, 0, 1, 1, 1};
    logic [7:0] exp_py [6] = '{0, 1, 2, 0, 1, 2};
    logic [7:0] exp_it [6] = '{5, 5, 5, 5, 5, 3};
    logic       exp_in [6] = '{1, 1, 1, 1, 1, 0};
    logic [7:0] hold_iter;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_iter", 32'(out_iter), 0);
        rst = 1'b0;

        // c = 1.0: orbit 1, 2, 5 -> escapes after 3 iterations with n = 2
        start_scan(0, 16'h1000, 16'h0000, 0, 0, 1, 1, 100);
        wait_valid(1, cyc);
        chk("c1_latency", 32'(cyc), 14);
        chk("c1_iter", 32'(out_iter), 2);
        chk("c1_inset", 32'(out_inset), 0);
        chk("c1_px", 32'(out_px), 0);
        @(negedge clk);
        chk("c1_done", 32'(done), 1);
        chk("c1_busy_at_done", 32'(busy), 0);
        @(negedge clk);
        chk("c1_done_once", 32'(done), 0);

        // c = i: periodic orbit, never escapes
        start_scan(0, 16'h0000, 16'h1000, 0, 0, 1, 1, 100);
        wait_valid(1, cyc);
        chk("ci_latency", 32'(cyc), 402);
        chk("ci_iter", 32'(out_iter), 100);
        chk("ci_inset", 32'(out_inset), 1);
        wait_idle();

        start_scan(0, 16'h0000, 16'h1000, 0, 0, 1, 1, 0);
        wait_valid(1, cyc);
        chk("max0_latency", 32'(cyc), 2);
        chk("max0_iter", 32'(out_iter), 0);
        chk("max0_inset", 32'(out_inset), 1);
        wait_idle();

        // Julia, c = 0: z0 = 0.5 shrinks, z0 = 2.0 escapes on first step
        start_scan(1, 16'h0800, 16'h0000, 0, 0, 1, 1, 20);
        wait_valid(1, cyc);
        chk("jh_iter", 32'(out_iter), 20);
        chk("jh_inset", 32'(out_inset), 1);
        wait_idle();
        start_scan(1, 16'h2000, 16'h0000, 0, 0, 1, 1, 20);
        wait_valid(1, cyc);
        chk("j2_latency", 32'(cyc), 6);
        chk("j2_iter", 32'(out_iter), 0);
        chk("j2_inset", 32'(out_inset), 0);
        wait_idle();

        // Empty grid goes straight to DONE
        start_scan(0, 0, 0, 0, 0, 0, 3, 10);
        chk("empty_done", 32'(done), 1);
        chk("empty_valid", 32'(out_valid), 0);
        @(negedge clk);
        chk("empty_busy", 32'(busy), 0);

        // 2x3 Julia grid, p in {0, 0.5}, q in {0, 0.5, 1.0}; only (0.5, 1.0) escapes (n = 3)
        start_scan(1, 16'h0000, 16'h0000, 16'h0800, 16'h0800, 2, 3, 5);
        cyc = 1;
        for (int i = 0; i < 6; i++) begin
            wait_valid(cyc, cyc);
            chk($sformatf("grid_px%0d", i), 32'(out_px), 32'(exp_px[i]));
            chk($sformatf("grid_py%0d", i), 32'(out_py), 32'(exp_py[i]));
            chk($sformatf("grid_it%0d", i), 32'(out_iter), 32'(exp_it[i]));
            chk($sformatf("grid_in%0d", i), 32'(out_inset), 32'(exp_in[i]));
            cyc = 0;
        end
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("grid_done_count", 32'(ndone), 1);
        chk("grid_busy_end", 32'(busy), 0);

        // Backpressure on a 1x2 grid
        out_ready = 1'b0;
        start_scan(1, 16'h2000, 16'h0000, 0, 16'h0100, 1, 2, 9);
        wait_valid(1, cyc);
        hold_iter = out_iter;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_py", 32'(out_py), 0);
            chk("bp_iter", 32'(out_iter), 32'(hold_iter));
        end
        out_ready = 1'b1;
        wait_valid(0, cyc);
        chk("bp_second_py", 32'(out_py), 1);
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) ndone++;
            chk("bp_no_extra", 32'(out_valid), 0);
        end
        chk("bp_done_count", 32'(ndone), 1);

        // Abort mid-iteration, then a normal run
        start_scan(0, 16'h0000, 16'h1000, 0, 0, 1, 1, 100);
        repeat (20) @(negedge clk);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(out_valid), 0);
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || out_valid) ndone++;
        end
        chk("abort_quiet", 32'(ndone), 0);
        start_scan(0, 16'h1000, 16'h0000, 0, 0, 1, 1, 100);
        wait_valid(1, cyc);
        chk("post_abort_latency", 32'(cyc), 14);
        chk("post_abort_iter", 32'(out_iter), 2);
        wait_idle();

        // cfg_start while busy must not recapture
        start_scan(0, 16'h0000, 16'h1000, 0, 0, 1, 1, 100);
        repeat (10) @(negedge clk);
        cfg_mode = 1'b1; cfg_cxs = 16'h2000; cfg_npx = 1; cfg_npy = 1; cfg_max_iter = 0;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        wait_valid(0, cyc);
        chk("busy_start_iter", 32'(out_iter), 100);
        chk("busy_start_inset", 32'(out_inset), 1);
        wait_idle();

        // Reset while holding a result in EMIT
        out_ready = 1'b0;
        start_scan(0, 0, 0, 0, 0, 1, 1, 0);
        wait_valid(1, cyc);
        chk("pre_rst_inset", 32'(out_inset), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_emit_valid", 32'(out_valid), 0);
        chk("rst_emit_busy", 32'(busy), 0);
        chk("rst_emit_inset", 32'(out_inset), 0);
        chk("rst_emit_iter", 32'(out_iter), 0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_emit_stays_idle", 32'(out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mandel_engine.md
Name: mandel_engine

Overview:
- Parametrised fixed-point escape-time engine that scans a rectangular grid of complex points and emits one iteration result per pixel.
- Successor to the fixed Q12 Mandelbrot iterator:
  - generic width and fraction bits
  - runtime region, grid size and iteration limit
  - Julia mode
  - start/done control
  - valid/ready output stream with backpressure
- Sits between the UART command decoder (config) and the framebuffer writer / TX path (result stream).

Parameters:
- N_BIT, 16, total fixed-point width, two's complement.
- BIT_FRAC, 12, fraction bits; 4.0 threshold = 4 << BIT_FRAC.
- PX_W, 8, width of pixel X counter and cfg_npx.
- PY_W, 8, width of pixel Y counter and cfg_npy.
- IT_W, 8, width of iteration counter and cfg_max_iter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cfg_start  in  1  start pulse; sampled only in IDLE
- cfg_abort  in  1  abandon current scan
- cfg_mode  in  1  0 = Mandelbrot, 1 = Julia
- cfg_cxs, cfg_cys  in  N_BIT  real/imag coordinate of pixel (0,0)
- cfg_dcx, cfg_dcy  in  N_BIT  per-pixel step in X / Y
- cfg_jx, cfg_jy  in  N_BIT  Julia constant c (ignored in mode 0)
- cfg_npx, cfg_npy  in  PX_W / PY_W  grid size in pixels
- cfg_max_iter  in  IT_W  iteration limit
- busy  out  1  high from accepted start until IDLE
- done  out  1  one-cycle pulse at end of a complete scan
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_px, out_py  out  PX_W / PY_W  pixel coordinate of result
- out_iter  out  IT_W  iteration count
- out_inset  out  1  1 = limit reached (in set), 0 = escaped

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all internal registers 0. Applies in any state; a pending result is dropped.
- Config capture:
  - All cfg_* latched in the cycle cfg_start is accepted (IDLE only).
  - cfg_start outside IDLE is ignored.
  - cfg inputs may change freely after capture.
- Scan order:
  - py inner loop, px outer: (0,0),(0,1)…(0,npy-1),(1,0)…
  - Coordinates built incrementally: p = cxs + px·dcx, q = cys + py·dcy, additions modulo 2^N_BIT.
- Seeds:
  - Mode 0: z0 = 0, c = (p,q).
  - Mode 1: z0 = (p,q), c = (jx,jy).
- Iteration step:
  - x' = x·x − y·y + cr
  - y' = 2·x·y + ci
  - Single shared multiplier.
- Multiply:
  - Sign-magnitude: magnitudes multiplied, result bits [BIT_FRAC+N_BIT−1 : BIT_FRAC] of the 2·N_BIT product (truncation toward zero), then sign applied.
  - 2·x formed by left shift; wraps.
- Additions wrap modulo 2^N_BIT.
- Escape test:
  - |x'| + |y'| ≥ 4.0, unsigned compare.
  - abs(most-negative) stays 0x8…0, treated as large (escapes).
- Counting: n starts at 0.
  - Escape → emit n, inset = 0.
  - Otherwise n++; if n == cfg_max_iter → emit n, inset = 1.
  - cfg_max_iter = 0 → every pixel emitted immediately: n = 0, inset = 1, no iteration.
- FSM: IDLE → INIT (load z0, n = 0; 1 cycle) → M_XX → M_YY → M_XY → CHK (exactly 4 cycles per iteration) → back to M_XX or to EMIT.
- EMIT:
  - out_valid = 1 with stable data.
  - Transfer on out_valid & out_ready.
  - Next cycle: INIT for next pixel, or DONE after last pixel.
  - Engine stalls in EMIT while out_ready = 0.
- DONE: done = 1 for one cycle, busy falls the same cycle, then IDLE.
- Empty grid: cfg_npx = 0 or cfg_npy = 0 → DONE directly after start, no outputs.
- cfg_abort (any non-IDLE state): next state IDLE, out_valid cleared, no done pulse. Ignored in IDLE.
- Simultaneous rst and cfg_start/cfg_abort: rst wins.
- Latency: first out_valid asserted 2 + 4·k cycles after accepted start, where k = iterations executed.

Test Plan:
- Defaults (N_BIT 16, BIT_FRAC 12), mode 0, single pixel c = (0x1000, 0), max 100 → out_iter = 2, inset = 0; out_valid first high 14 cycles after start.
- Mode 0, c = (0, 0x1000), max 100 → periodic orbit; out_iter = 100, inset = 1. Same with max_iter = 0 → out_iter = 0, inset = 1.
- Mode 1, jx = jy = 0:
  - z0 = (0x0800, 0) → inset = 1, out_iter = max.
  - z0 = (0x2000, 0) → out_iter = 0, inset = 0.
- npx = 2, npy = 3, out_ready = 1 → six results in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); single done pulse after the sixth; busy then 0.
- Backpressure:
  - out_ready low 10 cycles during EMIT → out_valid and data held constant, no further results.
  - Raise out_ready → scan continues; total count unchanged.
- Abort and reset:
  - cfg_abort mid-iteration → busy 0 next cycle, no done; new start then runs normally.
  - rst mid-EMIT → all outputs 0 next cycle.
  - cfg_start while busy → ignored.
